split_ram_responder: RTL
========================

Name: split_ram_responder

Overview:
- Target-side responder for the split-transaction memory bus driven by the CPU core: request channel req/ack/we/addr/wdata/be, response channel resp/rdata.
- Backs the bus with an on-chip word RAM, configurable request wait states, and a fixed-latency read-response pipeline.
- Instantiated once per bus (instr, data) in the sigma SoC, or standalone as a bench memory model.

Parameters:
MEM_WORDS, 1024, RAM depth in 32-bit words (power of 2)
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0
REQ_WAIT, 0, wait cycles inserted before each ack (0..15)
READ_LATENCY, 1, cycles from read accept to resp (1..8)
ERR_DATA, 32'hDEAD_BEEF, rdata returned for out-of-range reads

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
host_req  input  1  request valid
host_ack  output  1  request accepted this cycle
host_we  input  1  1 = write, 0 = read
host_addr  input  32  byte address
host_wdata  input  32  write data
host_be  input  4  byte enables, bit i -> wdata[8i+7:8i]
host_resp  output  1  read response valid, one-cycle pulse
host_rdata  output  32  read data, valid when host_resp=1
err_o  output  1  sticky: any out-of-range access since reset

Behaviour:
- Reset: host_ack=0, host_resp=0, host_rdata=0, err_o=0; wait counter=0; read pipeline valid bits cleared. RAM contents are not reset.
- Transfer rule: a request transfers in a cycle with host_req=1 and host_ack=1.
- Host protocol: host holds req and all fields stable until ack. Writes produce no response. Responses are never back-pressured.
- Wait FSM, states IDLE / WAIT:
  - REQ_WAIT=0: host_ack = host_req combinationally; FSM stays in IDLE.
  - REQ_WAIT>0, IDLE: host_req=1 -> WAIT with cnt=1, ack=0.
  - WAIT: ack=0 while cnt<REQ_WAIT, cnt increments each cycle. At cnt==REQ_WAIT, ack=1 (combinational from req) and the FSM returns to IDLE.
  - WAIT with host_req=0: return to IDLE, cnt=0. An aborted request is legal; it is not written and not answered.
  - Effect: each transfer takes REQ_WAIT+1 cycles of req.
- Address decode:
  - word index = (host_addr - BASE_ADDR) >> 2; addr[1:0] ignored.
  - In range: 0 <= index < MEM_WORDS, computed on 32-bit unsigned difference (addresses below BASE wrap high and are out of range).
- Write transfer, in range: at the clock edge, each RAM byte with be[i]=1 is updated. be=0 is accepted and changes nothing.
- Write transfer, out of range: dropped; err_o set.
- Read transfer:
  - At the accept edge, rdata is captured: RAM word, or ERR_DATA with err_o set if out of range.
  - The captured value enters a READ_LATENCY-stage shift pipeline (valid + data).
  - host_resp=1 exactly READ_LATENCY cycles after the accept cycle, for one cycle.
  - Responses are strictly in request order. Back-to-back reads yield back-to-back resp pulses.
  - host_rdata holds its last value when resp=0.
- Same-cycle write then read of the same word: a write accepted in cycle N is visible to a read accepted in cycle N+1 or later.
- Maximum reads in flight = READ_LATENCY. No overflow is possible because at most one accept occurs per cycle.
- Reset mid-operation: in-flight read responses are discarded (no resp after reset), the wait FSM goes to IDLE, and err_o clears.
- err_o: sticky until reset; never cleared by traffic.

Test Plan:
- Reset, REQ_WAIT=0, READ_LATENCY=1: write addr 0x10, wdata 0x12345678, be=4'hF; then read 0x10 -> ack same cycle as each req; resp one cycle after read accept with rdata 0x12345678.
- Byte enables: word 0x10 holds 0x12345678; write wdata 0xAABBCCDD, be=4'b0101; read -> rdata 0x12BB56DD.
- REQ_WAIT=3: hold a read req -> ack asserted on the 4th req cycle only. Drop req after 2 cycles, then reassert -> the count restarts; no resp is produced for the aborted request.
- READ_LATENCY=4: 6 back-to-back reads of words 0..5 holding 0..5 -> resp high for 6 consecutive cycles starting 4 cycles after the first accept; rdata 0,1,2,3,4,5 in order.
- Out of range, MEM_WORDS=1024, BASE=0: read 0x1000 -> rdata 0xDEADBEEF and err_o=1. A subsequent write to 0x1000 is dropped; err_o stays 1 until rst_i.
- Reset mid-flight: READ_LATENCY=4; assert rst_i one cycle after a read accept -> no resp pulse ever appears for it; host_ack=0 during reset; RAM data written before reset reads back intact afterwards.

Source files
------------

// File: rtl/split_ram_responder.sv
// split_ram_responder
//   Target-side responder for a split-transaction memory bus. Each bus
//   instance is backed by an on-chip 32-bit word RAM. An optional wait-state
//   FSM delays acceptance of each request. Reads return through a
//   fixed-latency shift pipeline, so responses come back in request order.
//
// Ports
//   clk_i       clock
//   rst_i       synchronous active-high reset
//   host_req    request valid; the host holds all fields stable until ack
//   host_ack    request accepted this cycle (combinational from host_req)
//   host_we     1 = write, 0 = read
//   host_addr   byte address; bits [1:0] are ignored
//   host_wdata  write data
//   host_be     byte enables, bit i -> wdata[8i+7:8i]
//   host_resp   read response valid, one-cycle pulse per accepted read
//   host_rdata  read data; holds its last value while host_resp = 0
//   err_o       sticky flag, set by any out-of-range access since reset

module split_ram_responder #(
  parameter int          MEM_WORDS    = 1024,          // power of 2
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          REQ_WAIT     = 0,             // 0..15
  parameter int          READ_LATENCY = 1,             // 1..8
  parameter logic [31:0] ERR_DATA     = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        host_req,
  output logic        host_ack,
  input  logic        host_we,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  input  logic [3:0]  host_be,
  output logic        host_resp,
  output logic [31:0] host_rdata,
  output logic        err_o
);

  localparam int         AW     = $clog2(MEM_WORDS);
  localparam logic [3:0] WAIT_N = 4'(REQ_WAIT);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        ack_c;

  // ---------------------------------------------------------------------
  // Wait-state FSM. Acknowledge is combinational from host_req so that a
  // zero-wait responder accepts in the same cycle the request appears.
  // ---------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    ack_c = 1'b0;
    if (REQ_WAIT == 0)
      ack_c = host_req;
    else if (state == ST_WAIT && cnt == WAIT_N)
      ack_c = host_req;
  end

  // Nothing is accepted while reset is held.
  assign host_ack = ack_c & ~rst_i;

  // NOTE: sequential state is updated with non-blocking assignments so all
  // registers sample their inputs from the same clock edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (REQ_WAIT != 0) begin
      case (state)
        ST_IDLE: begin
          if (host_req) begin
            state <= ST_WAIT;
            cnt   <= 4'd1;
          end
        end
        ST_WAIT: begin
          // Either the request was withdrawn (abort) or it is being
          // acknowledged this cycle; both cases restart the count.
          if (!host_req || cnt == WAIT_N) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Address decode. The offset is an unsigned 32-bit difference, so
  // addresses below BASE_ADDR wrap high and fall out of range.
  // ---------------------------------------------------------------------
  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          unused_low;

  assign offset     = host_addr - BASE_ADDR;
  assign in_range   = (offset[31:AW+2] == '0);
  assign idx        = offset[AW+1:2];
  assign unused_low = ^offset[1:0];

  logic accept, wr_accept, rd_accept;
  assign accept    = host_req & host_ack;
  assign wr_accept = accept &  host_we & in_range;
  assign rd_accept = accept & ~host_we;

  // ---------------------------------------------------------------------
  // Word RAM with byte-lane writes.
  // ---------------------------------------------------------------------
  logic [31:0] mem [MEM_WORDS];

  // NOTE: the RAM array has no reset; clearing it would prevent mapping to
  // a RAM macro, and its contents must survive rst_i anyway.
  always_ff @(posedge clk_i) begin
    if (wr_accept) begin
      for (int b = 0; b < 4; b++) begin
        if (host_be[b])
          mem[idx][8*b +: 8] <= host_wdata[8*b +: 8];
      end
    end
  end

  logic [31:0] rd_word;
  assign rd_word = in_range ? mem[idx] : ERR_DATA;

  // ---------------------------------------------------------------------
  // Sticky error flag.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i)
      err_o <= 1'b0;
    else if (accept && !in_range)
      err_o <= 1'b1;
  end

  // ---------------------------------------------------------------------
  // Read-response pipeline. Stage 0 captures at the accept edge; the last
  // stage drives the outputs. Data stages only load behind a valid entry,
  // so host_rdata holds its last value between responses.
  // ---------------------------------------------------------------------
  logic [READ_LATENCY-1:0] pipe_v;
  logic [31:0]             pipe_d [READ_LATENCY];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_v <= '0;
      for (int i = 0; i < READ_LATENCY; i++)
        pipe_d[i] <= '0;
    end else begin
      pipe_v[0] <= rd_accept;
      if (rd_accept)
        pipe_d[0] <= rd_word;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1])
          pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign host_resp  = pipe_v[READ_LATENCY-1];
  assign host_rdata = pipe_d[READ_LATENCY-1];

endmodule
